fpu_add_writeback: RTL and testbench
====================================

Name: fpu_add_writeback

Overview:
Registered output stage directly downstream of the combinational FP adder/subtractor. It captures each adder result together with its exception flags and destination tag into a small in-order buffer, and NaN-boxes single-precision results. It retires entries to the register-file write port over a valid/ready handshake and accumulates retired exception flags into a sticky fflags register. That register can be read and written by the CSR unit.

Parameters:
DEPTH, 2, buffer entries; power of two, >= 2
TAG_W, 5, destination register tag width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  adder result valid
in_ready  out  1  stage can accept an entry this cycle
in_result  in  64  adder result
in_is_double  in  1  1 = DP result, 0 = SP result in bits [31:0]
in_tag  in  TAG_W  destination register tag
in_flag_invalid  in  1  NV from adder
in_flag_overflow  in  1  OF from adder
in_flag_underflow  in  1  UF from adder
in_flag_inexact  in  1  NX from adder
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head entry
out_result  out  64  head result, NaN-boxed when SP
out_tag  out  TAG_W  head tag
out_flags  out  5  head flags {NV,DZ,OF,UF,NX}
flush  in  1  synchronous discard of all buffered entries
csr_we  in  1  write fflags
csr_wdata  in  5  fflags write data
fflags  out  5  sticky accumulated flags {NV,DZ,OF,UF,NX}
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (rst_n low, asynchronous): buffer empty, rd/wr pointers 0, count 0, out_valid 0, fflags 0. out_result, out_tag and out_flags are driven 0 while empty.
- Push when in_valid & in_ready. in_ready = (count < DEPTH) & ~flush. There is no combinational path from out_ready to in_ready: a full buffer does not accept input even if it pops in the same cycle.
- Stored entry: result, tag, flags. DZ is always stored as 0. SP entry stores {32'hFFFF_FFFF, in_result[31:0]}. DP entry stores in_result unchanged.
- Latency: an entry pushed at edge N is visible at out_valid/out_* after edge N. There is no input-to-output bypass. out_* reflect the head entry combinationally from storage.
- Pop when out_valid & out_ready. out_valid = (count != 0). Order is strictly FIFO.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Holding rule: out_* must stay stable while out_valid & ~out_ready.
- flush: at the next edge, count, rd pointer and wr pointer go to 0. Any pop in the flush cycle is treated as not retired, so its flags are not accumulated. fflags is otherwise unaffected.
- fflags update per edge: fflags_next = (csr_we ? csr_wdata : fflags) | (retire ? head_flags : 5'b0), where retire = pop & ~flush. A CSR write and a retire in the same cycle both take effect; the retiring flags are ORed on top of the written value.
- Reset mid-operation discards all entries immediately. No handshake is issued for discarded entries.

Decomposition:
- fpu_pkg:
  - fflags bit indices: FFLAG_NV=4, FFLAG_DZ=3, FFLAG_OF=2, FFLAG_UF=1, FFLAG_NX=0
  - constant NANBOX_HI = 32'hFFFF_FFFF
  - typedef wb_entry_t {result[63:0], tag, flags[4:0]}
- Sub-module fpu_sync_fifo: a generic DEPTH-entry FIFO of wb_entry_t with push/pop/flush/count. fpu_add_writeback wraps it with NaN-boxing, flag packing and fflags accumulation.

Test Plan:
- Single DP push: result=64'h4000_0000_0000_0000, tag=3, NX=1, out_ready=1 -> out_valid high exactly one cycle later with identical result and tag, out_flags=5'b00001; after the pop, fflags=5'b00001.
- SP boxing: in_is_double=0, in_result=64'h0000_0000_3F80_0000 -> out_result=64'hFFFF_FFFF_3F80_0000.
- Backpressure with out_ready=0 and DEPTH=2: two pushes leave count=2 and in_ready=0; a third in_valid is ignored. Then raise out_ready -> entries emerge in order, one per cycle, and in_ready returns the cycle after the first pop.
- Simultaneous push/pop at count=1 -> count stays 1; FIFO order holds across pointer wrap for 10 back-to-back entries.
- csr_we with csr_wdata=5'b00000 in the same cycle as retiring an entry carrying OF|NX -> fflags=5'b00101. csr_we alone with 5'b10000 -> fflags=5'b10000.
- flush with 2 entries buffered, one flagged NV, out_ready=1 -> count=0 next cycle and fflags unchanged. Assert rst_n low mid-stream -> out_valid, count and fflags are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP adder writeback stage: fflags bit layout,
// NaN-boxing constant, buffered entry record and small helpers.
package fpu_pkg;

   localparam int FFLAG_NV = 4;
   localparam int FFLAG_DZ = 3;
   localparam int FFLAG_OF = 2;
   localparam int FFLAG_UF = 1;
   localparam int FFLAG_NX = 0;

   localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;
   localparam int          WB_TAG_W  = 5;

   typedef struct packed {
      logic [63:0]         result;
      logic [WB_TAG_W-1:0] tag;
      logic [4:0]          flags;
   } wb_entry_t;

   // Single-precision values live in the low word with the upper word all ones.
   function automatic logic [63:0] nan_box(input logic [63:0] result, input logic is_double);
      logic [63:0] boxed;
      if (is_double) begin
         boxed = result;
      end else begin
         boxed = {NANBOX_HI, result[31:0]};
      end
      return boxed;
   endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Generic in-order buffer with push/pop/flush and occupancy count.
// Flush has priority over push and pop; pops on an empty buffer are ignored.
module fpu_sync_fifo
   import fpu_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = $bits(wb_entry_t)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (count_r == CNT_W'(DEPTH));
   assign empty     = (count_r == {CNT_W{1'b0}});
   assign do_push_s = push & ~full & ~flush;
   assign do_pop_s  = pop & ~empty & ~flush;
   assign rd_data   = mem_r[rd_ptr_r];
   assign count     = count_r;

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage, cleared on reset so the head never presents stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (do_push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

endmodule

// File: rtl/fpu_add_writeback.sv
// Writeback stage after the FP adder: buffers results with tag and flags,
// NaN-boxes SP values, retires over valid/ready and accumulates sticky fflags.
module fpu_add_writeback
   import fpu_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int TAG_W = WB_TAG_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [63:0]            in_result,
   input  logic                   in_is_double,
   input  logic [TAG_W-1:0]       in_tag,
   input  logic                   in_flag_invalid,
   input  logic                   in_flag_overflow,
   input  logic                   in_flag_underflow,
   input  logic                   in_flag_inexact,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [63:0]            out_result,
   output logic [TAG_W-1:0]       out_tag,
   output logic [4:0]             out_flags,
   input  logic                   flush,
   input  logic                   csr_we,
   input  logic [4:0]             csr_wdata,
   output logic [4:0]             fflags,
   output logic [$clog2(DEPTH):0] count
);

   typedef struct packed {
      logic [63:0]      result;
      logic [TAG_W-1:0] tag;
      logic [4:0]       flags;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   entry_t               wr_entry_s;
   entry_t               rd_entry_s;
   logic [ENTRY_W-1:0]   rd_bits_s;
   logic                 full_s;
   logic                 empty_s;
   logic                 push_s;
   logic                 pop_s;
   logic                 retire_s;
   logic [4:0]           fflags_r;
   logic [4:0]           fflags_next_s;

   // Full alone gates input: a same-cycle pop never frees a slot early.
   assign in_ready  = ~full_s & ~flush;
   assign out_valid = ~empty_s;
   assign push_s    = in_valid & in_ready;
   assign pop_s     = out_valid & out_ready;
   assign retire_s  = pop_s & ~flush;
   assign fflags    = fflags_r;

   // Build the stored record; divide-by-zero can never come from an adder.
   always_comb begin
      wr_entry_s        = '0;
      wr_entry_s.result = nan_box(in_result, in_is_double);
      wr_entry_s.tag    = in_tag;
      wr_entry_s.flags[FFLAG_NV] = in_flag_invalid;
      wr_entry_s.flags[FFLAG_DZ] = 1'b0;
      wr_entry_s.flags[FFLAG_OF] = in_flag_overflow;
      wr_entry_s.flags[FFLAG_UF] = in_flag_underflow;
      wr_entry_s.flags[FFLAG_NX] = in_flag_inexact;
   end

   fpu_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_s),
      .pop     (pop_s),
      .flush   (flush),
      .wr_data (wr_entry_s),
      .rd_data (rd_bits_s),
      .count   (count),
      .full    (full_s),
      .empty   (empty_s)
   );

   assign rd_entry_s = entry_t'(rd_bits_s);

   // Present the head entry, forcing zeros while nothing is buffered.
   always_comb begin
      out_result = 64'h0;
      out_tag    = {TAG_W{1'b0}};
      out_flags  = 5'b00000;
      if (out_valid) begin
         out_result = rd_entry_s.result;
         out_tag    = rd_entry_s.tag;
         out_flags  = rd_entry_s.flags;
      end else begin
         out_result = 64'h0;
         out_tag    = {TAG_W{1'b0}};
         out_flags  = 5'b00000;
      end
   end

   // A CSR write and a retire in the same cycle both land: retiring flags OR on top.
   always_comb begin
      fflags_next_s = fflags_r;
      if (csr_we) begin
         fflags_next_s = csr_wdata;
      end else begin
         fflags_next_s = fflags_r;
      end
      if (retire_s) begin
         fflags_next_s = fflags_next_s | rd_entry_s.flags;
      end else begin
         fflags_next_s = fflags_next_s | 5'b00000;
      end
   end

   // Sticky exception flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fflags_r <= 5'b00000;
      end else begin
         fflags_r <= fflags_next_s;
      end
   end

endmodule

// File: tb/tb_fpu_add_writeback.sv
// Self-checking bench for fpu_add_writeback: directed vector table, a queue-based
// reference model under random traffic, and an asynchronous mid-stream reset.
module tb_fpu_add_writeback;

   localparam int DEPTH = 2;
   localparam int TAG_W = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_result;
   logic          in_is_double;
   logic [TAG_W-1:0] in_tag;
   logic          in_flag_invalid, in_flag_overflow, in_flag_underflow, in_flag_inexact;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   out_result;
   logic [TAG_W-1:0] out_tag;
   logic [4:0]    out_flags;
   logic          flush;
   logic          csr_we;
   logic [4:0]    csr_wdata;
   logic [4:0]    fflags;
   logic [1:0]    count;

   int checks = 0;
   int errors = 0;

   fpu_add_writeback #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_is_double(in_is_double), .in_tag(in_tag),
      .in_flag_invalid(in_flag_invalid), .in_flag_overflow(in_flag_overflow),
      .in_flag_underflow(in_flag_underflow), .in_flag_inexact(in_flag_inexact),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_tag(out_tag), .out_flags(out_flags), .flush(flush), .csr_we(csr_we),
      .csr_wdata(csr_wdata), .fflags(fflags), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   // fl = {NV, OF, UF, NX}
   typedef struct {
      logic        iv;   logic [63:0] res; logic dbl; logic [4:0] tag; logic [3:0] fl;
      logic        ordy; logic fsh; logic we; logic [4:0] wd;
      logic        ov;   logic [63:0] eres; logic [4:0] etag; logic [4:0] efl;
      logic [1:0]  ecnt; logic [4:0] eff; logic eird;
   } vec_t;

   function automatic vec_t mk(input logic iv, input logic [63:0] res, input logic dbl,
                               input logic [4:0] tag, input logic [3:0] fl, input logic ordy,
                               input logic fsh, input logic we, input logic [4:0] wd,
                               input logic ov, input logic [63:0] eres, input logic [4:0] etag,
                               input logic [4:0] efl, input logic [1:0] ecnt,
                               input logic [4:0] eff, input logic eird);
      vec_t v;
      v.iv = iv; v.res = res; v.dbl = dbl; v.tag = tag; v.fl = fl;
      v.ordy = ordy; v.fsh = fsh; v.we = we; v.wd = wd;
      v.ov = ov; v.eres = eres; v.etag = etag; v.efl = efl;
      v.ecnt = ecnt; v.eff = eff; v.eird = eird;
      return v;
   endfunction

   // Reference model: queue of stored entries plus the sticky flag word.
   typedef struct {
      logic [63:0] res;
      logic [4:0]  tag;
      logic [4:0]  fl;
   } ment_t;
   ment_t      mq[$];
   logic [4:0] mff;

   task automatic drive_idle();
      in_valid = 1'b0; in_result = 64'h0; in_is_double = 1'b1; in_tag = 5'd0;
      in_flag_invalid = 1'b0; in_flag_overflow = 1'b0;
      in_flag_underflow = 1'b0; in_flag_inexact = 1'b0;
      out_ready = 1'b0; flush = 1'b0; csr_we = 1'b0; csr_wdata = 5'd0;
   endtask

   task automatic check_model();
      chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
      chk("count", {62'd0, count}, 64'(mq.size()));
      chk("in_ready", {63'd0, in_ready}, {63'd0, (mq.size() < DEPTH) && !flush});
      chk("fflags", {59'd0, fflags}, {59'd0, mff});
      if (mq.size() != 0) begin
         chk("out_result", out_result, mq[0].res);
         chk("out_tag", {59'd0, out_tag}, {59'd0, mq[0].tag});
         chk("out_flags", {59'd0, out_flags}, {59'd0, mq[0].fl});
      end else begin
         chk("out_result_empty", out_result, 64'h0);
      end
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      bit         push, pop;
      ment_t      e;
      logic [4:0] hf;
      push = in_valid && (mq.size() < DEPTH) && !flush;
      pop  = (mq.size() != 0) && out_ready;
      hf   = pop ? mq[0].fl : 5'b00000;
      mff  = (csr_we ? csr_wdata : mff) | ((pop && !flush) ? hf : 5'b00000);
      e.res = in_is_double ? in_result : {32'hFFFF_FFFF, in_result[31:0]};
      e.tag = in_tag;
      e.fl  = {in_flag_invalid, 1'b0, in_flag_overflow, in_flag_underflow, in_flag_inexact};
      if (flush) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back(e);
      end
   endtask

   task automatic mcycle();
      #4;
      check_model();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic rand_inputs();
      in_valid          = ($urandom_range(0, 99) < 60);
      in_result         = {$urandom, $urandom};
      in_is_double      = 1'($urandom_range(0, 1));
      in_tag            = 5'($urandom_range(0, 31));
      in_flag_invalid   = 1'($urandom_range(0, 1));
      in_flag_overflow  = 1'($urandom_range(0, 1));
      in_flag_underflow = 1'($urandom_range(0, 1));
      in_flag_inexact   = 1'($urandom_range(0, 1));
      out_ready         = ($urandom_range(0, 99) < 65);
      flush             = ($urandom_range(0, 15) == 0);
      csr_we            = ($urandom_range(0, 7) == 0);
      csr_wdata         = 5'($urandom_range(0, 31));
   endtask

   task automatic async_reset_check();
      in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
      csr_we = 1'b1; csr_wdata = 5'b11111;
      mcycle();
      csr_we = 1'b0;
      mcycle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_count", {62'd0, count}, 64'd0);
      chk("rst_fflags", {59'd0, fflags}, 64'd0);
      chk("rst_out_result", out_result, 64'h0);
      mq.delete();
      mff = 5'b00000;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   vec_t vecs[$];

   initial begin
      logic [63:0] ra, rb, rc, rd, re, rf, rg;
      ra = 64'h1111_2222_3333_4444; rb = 64'h5555_6666_7777_8888;
      rc = 64'h9999_AAAA_BBBB_CCCC; rd = 64'h0123_4567_89AB_CDEF;
      re = 64'hDEAD_BEEF_4049_0FDB; rf = 64'h7FF8_0000_0000_0000;
      rg = 64'h3FF0_0000_0000_0000;
      // DP push with NX, then retire
      vecs.push_back(mk(1'b1, 64'h4000_0000_0000_0000, 1'b1, 5'd3, 4'b0001, 1'b1, 1'b0, 1'b0, 5'd0,
                        1'b1, 64'h4000_0000_0000_0000, 5'd3, 5'b00001, 2'd1, 5'b00000, 1'b1));
      vecs.push_back(mk(1'b0, 64'h0, 1'b1, 5'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0,
                        1'b0, 64'h0, 5'd0, 5'b00000, 2'd0, 5'b00001, 1'b1));
      // SP boxing
      vecs.push_back(mk(1'b1, 64'h0000_0000_3F80_0000, 1'b0, 5'd7, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0,
                        1'b1, 64'hFFFF_FFFF_3F80_0000, 5'd7, 5'b00000, 2'd1, 5'b00001, 1'b1));
      vecs.push_back(mk(1'b0, 64'h0, 1'b1, 5'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0,
                        1'b0, 64'h0, 5'd0, 5'b00000, 2'd0, 5'b00001, 1'b1));
      // Backpressure: fill, ignored third push, drain in order
      vecs.push_back(mk(1'b1, ra, 1'b1, 5'd1, 4'b0100, 1'b0, 1'b0, 1'b0, 5'd0,
                        1'b1, ra, 5'd1, 5'b00100, 2'd1, 5'b00001, 1'b1));
      vecs.push_back(mk(1'b1, rb, 1'b1, 5'd2, 4'b0010, 1'b0, 1'b0, 1'b0, 5'd0,
                        1'b1, ra, 5'd1, 5'b00100, 2'd2, 5'b00001, 1'b0));
      vecs.push_back(mk(1'b1, rc, 1'b1, 5'd4, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0,
                        1'b1, ra, 5'd1, 5'b00100, 2'd2, 5'b00001, 1'b0));
      vecs.push_back(mk(1'b1, rc, 1'b1, 5'd4, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0,
                        1'b1, rb, 5'd2, 5'b00010, 2'd1, 5'b00101, 1'b1));
      vecs.push_back(mk(1'b0, 64'h0, 1'b1, 5'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0,
                        1'b0, 64'h0, 5'd0, 5'b00000, 2'd0, 5'b00111, 1'b1));
      // Simultaneous push/pop at count 1
      vecs.push_back(mk(1'b1, rd, 1'b1, 5'd5, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0,
                        1'b1, rd, 5'd5, 5'b00000, 2'd1, 5'b00111, 1'b1));
      vecs.push_back(mk(1'b1, re, 1'b0, 5'd6, 4'b0101, 1'b1, 1'b0, 1'b0, 5'd0,
                        1'b1, 64'hFFFF_FFFF_4049_0FDB, 5'd6, 5'b00101, 2'd1, 5'b00111, 1'b1));
      // CSR write of zero with a retire carrying OF|NX, then plain writes
      vecs.push_back(mk(1'b0, 64'h0, 1'b1, 5'd0, 4'b0000, 1'b1, 1'b0, 1'b1, 5'b00000,
                        1'b0, 64'h0, 5'd0, 5'b00000, 2'd0, 5'b00101, 1'b1));
      vecs.push_back(mk(1'b0, 64'h0, 1'b1, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 5'b10000,
                        1'b0, 64'h0, 5'd0, 5'b00000, 2'd0, 5'b10000, 1'b1));
      vecs.push_back(mk(1'b0, 64'h0, 1'b1, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 5'b00010,
                        1'b0, 64'h0, 5'd0, 5'b00000, 2'd0, 5'b00010, 1'b1));
      // Flush with an NV entry at the head being popped
      vecs.push_back(mk(1'b1, rf, 1'b1, 5'd8, 4'b1000, 1'b0, 1'b0, 1'b0, 5'd0,
                        1'b1, rf, 5'd8, 5'b10000, 2'd1, 5'b00010, 1'b1));
      vecs.push_back(mk(1'b1, rg, 1'b1, 5'd9, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0,
                        1'b1, rf, 5'd8, 5'b10000, 2'd2, 5'b00010, 1'b0));
      vecs.push_back(mk(1'b0, 64'h0, 1'b1, 5'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd0,
                        1'b0, 64'h0, 5'd0, 5'b00000, 2'd0, 5'b00010, 1'b0));
      vecs.push_back(mk(1'b0, 64'h0, 1'b1, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0,
                        1'b0, 64'h0, 5'd0, 5'b00000, 2'd0, 5'b00010, 1'b1));

      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_count", {62'd0, count}, 64'd0);
      chk("reset_fflags", {59'd0, fflags}, 64'd0);
      chk("reset_out_result", out_result, 64'h0);
      chk("reset_out_tag", {59'd0, out_tag}, 64'd0);
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         in_valid = vecs[i].iv; in_result = vecs[i].res; in_is_double = vecs[i].dbl;
         in_tag = vecs[i].tag;
         {in_flag_invalid, in_flag_overflow, in_flag_underflow, in_flag_inexact} = vecs[i].fl;
         out_ready = vecs[i].ordy; flush = vecs[i].fsh;
         csr_we = vecs[i].we; csr_wdata = vecs[i].wd;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].ov});
         chk($sformatf("v%0d_out_result", i), out_result, vecs[i].eres);
         chk($sformatf("v%0d_out_tag", i), {59'd0, out_tag}, {59'd0, vecs[i].etag});
         chk($sformatf("v%0d_out_flags", i), {59'd0, out_flags}, {59'd0, vecs[i].efl});
         chk($sformatf("v%0d_count", i), {62'd0, count}, {62'd0, vecs[i].ecnt});
         chk($sformatf("v%0d_fflags", i), {59'd0, fflags}, {59'd0, vecs[i].eff});
         chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].eird});
      end

      // Model takes over from the state the table leaves behind.
      mq.delete();
      mff = 5'b00010;
      drive_idle();

      // Ten back-to-back entries across pointer wrap.
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_is_double = 1'b1;
         in_result = 64'hA000_0000_0000_0000 + 64'(i);
         in_tag = 5'(i); out_ready = 1'b1;
         mcycle();
      end
      in_valid = 1'b0;
      repeat (2) mcycle();

      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            async_reset_check();
         end
         rand_inputs();
         mcycle();
      end
      drive_idle();
      out_ready = 1'b1;
      repeat (3) mcycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
